// File: rtl/net2axis_pkt_fifo.sv
// Store-and-forward AXI4-Stream packet buffer ahead of the net2axis capture sink.
// Packets become visible downstream only once complete; packets that cannot fit are dropped whole.
module net2axis_pkt_fifo #(
    parameter int unsigned C_TDATA_WIDTH = 32,
    parameter int unsigned C_DEPTH       = 16,
    parameter int unsigned C_CNT_WIDTH   = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       S_AXIS_TVALID,
    input  logic [C_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic                       S_AXIS_TLAST,
    output logic                       S_AXIS_TREADY,
    output logic                       M_AXIS_TVALID,
    output logic [C_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                       M_AXIS_TLAST,
    input  logic                       M_AXIS_TREADY,
    output logic [C_CNT_WIDTH-1:0]     PKT_CNT,
    output logic [C_CNT_WIDTH-1:0]     DROP_CNT
);

    localparam int unsigned KeepW = C_TDATA_WIDTH / 8;
    localparam int unsigned AddrW = $clog2(C_DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;

    typedef enum logic [0:0] {StAccept, StDrop} wr_state_e;

    wr_state_e              state_q, state_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        wr_commit_q, wr_commit_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [C_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [C_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                   tready_q;

    logic [C_TDATA_WIDTH-1:0] mem_data [C_DEPTH];
    logic [KeepW-1:0]         mem_keep [C_DEPTH];
    logic                     mem_last [C_DEPTH];

    logic             in_fire, full, store, commit;
    logic             out_valid, out_fire, out_last;
    logic [AddrW-1:0] wr_idx, rd_idx;

    assign wr_idx    = wr_ptr_q[AddrW-1:0];
    assign rd_idx    = rd_ptr_q[AddrW-1:0];
    assign in_fire   = S_AXIS_TVALID & tready_q;
    // Registered pointers only: a same-cycle read does not free a slot for this write.
    assign full      = (wr_ptr_q - rd_ptr_q) == PtrW'(C_DEPTH);
    assign store     = in_fire & (state_q == StAccept) & ~full;
    assign commit    = store & S_AXIS_TLAST;
    assign out_valid = rd_ptr_q != wr_commit_q;
    assign out_fire  = out_valid & M_AXIS_TREADY;
    assign out_last  = mem_last[rd_idx];

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_cnt_d   = pkt_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        unique case (state_q)
            StAccept: begin
                if (in_fire) begin
                    if (!full) begin
                        wr_ptr_d = wr_ptr_q + PtrW'(1);
                        if (S_AXIS_TLAST) begin
                            wr_commit_d = wr_ptr_q + PtrW'(1);
                        end
                    end else begin
                        // Rewind discards the partial packet already written.
                        wr_ptr_d = wr_commit_q;
                        if (drop_cnt_q != '1) begin
                            drop_cnt_d = drop_cnt_q + C_CNT_WIDTH'(1);
                        end
                        if (!S_AXIS_TLAST) begin
                            state_d = StDrop;
                        end
                    end
                end
            end
            StDrop: begin
                if (in_fire && S_AXIS_TLAST) begin
                    state_d = StAccept;
                end
            end
            default: state_d = StAccept;
        endcase

        if (out_fire) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({commit, out_fire & out_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + C_CNT_WIDTH'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - C_CNT_WIDTH'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q     <= StAccept;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            tready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            tready_q    <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (store) begin
            mem_data[wr_idx] <= S_AXIS_TDATA;
            mem_keep[wr_idx] <= S_AXIS_TKEEP;
            mem_last[wr_idx] <= S_AXIS_TLAST;
        end
    end

    assign S_AXIS_TREADY = tready_q;
    assign M_AXIS_TVALID = out_valid;
    assign M_AXIS_TDATA  = mem_data[rd_idx];
    assign M_AXIS_TKEEP  = mem_keep[rd_idx];
    assign M_AXIS_TLAST  = out_last;
    assign PKT_CNT       = pkt_cnt_q;
    assign DROP_CNT      = drop_cnt_q;

endmodule
